// File: rtl/mem_arb_if.sv
// Request/response channels of the IFU and LSU plus the shared memory pins.
// "slave" is the arbiter side, "master" is the requester/memory environment side.
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_req_vld;
  logic          ifu_req_rdy;
  logic [AW-1:0] ifu_req_pc;
  logic          ifu_rsp_vld;
  logic          ifu_rsp_rdy;
  logic [DW-1:0] ifu_rsp_inst;

  logic          lsu_req_vld;
  logic          lsu_req_rdy;
  logic [AW-1:0] lsu_req_addr;
  logic          lsu_req_wen;
  logic [DW-1:0] lsu_req_wdata;
  logic          lsu_rsp_vld;
  logic          lsu_rsp_rdy;
  logic [DW-1:0] lsu_rsp_rdata;

  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] wdata;
  logic          wen;

  modport slave (
    input  ifu_req_vld, ifu_req_pc, ifu_rsp_rdy,
    input  lsu_req_vld, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_rsp_rdy,
    input  rdata,
    output ifu_req_rdy, ifu_rsp_vld, ifu_rsp_inst,
    output lsu_req_rdy, lsu_rsp_vld, lsu_rsp_rdata,
    output addr, wdata, wen
  );

  modport master (
    output ifu_req_vld, ifu_req_pc, ifu_rsp_rdy,
    output lsu_req_vld, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_rsp_rdy,
    output rdata,
    input  ifu_req_rdy, ifu_rsp_vld, ifu_rsp_inst,
    input  lsu_req_rdy, lsu_rsp_vld, lsu_rsp_rdata,
    input  addr, wdata, wen
  );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one synchronous memory port between IFU and LSU,
// with a one-entry response buffer for backpressured read data.
module mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic       clk,
  input logic       rst_n,
  mem_arb_if.slave  bus
);

  logic          prio;
  logic          infl_vld;
  logic          infl_own;
  logic          hold_vld;
  logic          hold_own;
  logic [DW-1:0] hold_data;

  logic          owner_rsp_rdy;
  logic          hold_rsp_rdy;
  logic          stall;
  logic          gnt_ifu;
  logic          gnt_lsu;
  logic          rsp_vld;
  logic          rsp_own;
  logic [DW-1:0] rsp_data;
  logic          hold_capture;

  // Grant stage: arbitration and memory drive in the request cycle
  always_comb begin
    owner_rsp_rdy = infl_own ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy;
    hold_rsp_rdy  = hold_own ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy;
    stall         = hold_vld | (infl_vld & ~owner_rsp_rdy);
    gnt_ifu       = rst_n & ~stall & bus.ifu_req_vld & (~bus.lsu_req_vld | ~prio);
    gnt_lsu       = rst_n & ~stall & bus.lsu_req_vld & (~bus.ifu_req_vld | prio);
  end

  assign bus.ifu_req_rdy = gnt_ifu;
  assign bus.lsu_req_rdy = gnt_lsu;
  assign bus.addr        = !rst_n  ? '0 :
                           gnt_lsu ? bus.lsu_req_addr : bus.ifu_req_pc;
  assign bus.wdata       = bus.lsu_req_wdata;
  assign bus.wen         = gnt_lsu & bus.lsu_req_wen;

  // Response stage: a held beat takes precedence over the live rdata beat
  always_comb begin
    rsp_vld  = rst_n & (hold_vld | infl_vld);
    rsp_own  = hold_vld ? hold_own : infl_own;
    rsp_data = hold_vld ? hold_data : bus.rdata;
  end

  assign bus.ifu_rsp_vld   = rsp_vld & ~rsp_own;
  assign bus.lsu_rsp_vld   = rsp_vld & rsp_own;
  assign bus.ifu_rsp_inst  = bus.ifu_rsp_vld ? rsp_data : '0;
  assign bus.lsu_rsp_rdata = bus.lsu_rsp_vld ? rsp_data : '0;

  // A fresh beat that its owner refuses must be captured before rdata moves on
  assign hold_capture = ~hold_vld & infl_vld & ~owner_rsp_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio     <= 1'b0;
      infl_vld <= 1'b0;
      infl_own <= 1'b0;
      hold_vld <= 1'b0;
      hold_own <= 1'b0;
    end else begin
      if (gnt_ifu) begin
        prio <= 1'b1;
      end else if (gnt_lsu) begin
        prio <= 1'b0;
      end
      infl_vld <= gnt_ifu | (gnt_lsu & ~bus.lsu_req_wen);
      infl_own <= gnt_lsu;
      if (hold_vld) begin
        if (hold_rsp_rdy) begin
          hold_vld <= 1'b0;
        end
      end else if (hold_capture) begin
        hold_vld <= 1'b1;
        hold_own <= infl_own;
      end
    end
  end

  // Held data is only observed while hold_vld is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (hold_capture) begin
      hold_data <= bus.rdata;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_mem_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous memory: rdata follows addr by one cycle, writes commit at the edge
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    bus.rdata <= mem[bus.addr[11:2]];
    if (bus.wen) mem[bus.addr[11:2]] = bus.wdata;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic lv,
                       input logic [31:0] la, input logic lw, input logic [31:0] wd,
                       input logic ir, input logic lr);
    bus.ifu_req_vld   = iv;
    bus.ifu_req_pc    = pc;
    bus.lsu_req_vld   = lv;
    bus.lsu_req_addr  = la;
    bus.lsu_req_wen   = lw;
    bus.lsu_req_wdata = wd;
    bus.ifu_rsp_rdy   = ir;
    bus.lsu_rsp_rdy   = lr;
  endtask

  task automatic cycle(input logic iv, input logic [31:0] pc, input logic lv,
                       input logic [31:0] la, input logic lw, input logic [31:0] wd,
                       input logic ir, input logic lr);
    @(posedge clk); #1;
    drive(iv, pc, lv, la, lw, wd, ir, lr);
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [31:0] wd;
    logic        ir;
    logic        lr;
    logic        e_ir;
    logic        e_lr;
    logic        e_wen;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_id;
    logic        e_lv;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vec [14];

  // Reference model state (transaction level)
  logic        pend_vld, pend_own, pend_first;
  logic [31:0] pend_data;
  logic        fav_lsu;
  logic        iv, lv, lw, ir, lr, ihs, lhs;
  logic [31:0] pc, la, wd;
  logic        e_ig, e_lg, can, own_rdy;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA000_0000 | (i << 2);
      ref_mem[i] = 32'hA000_0000 | (i << 2);
    end
    mem[32'h100 >> 2] = 32'h0000_0013;  ref_mem[32'h100 >> 2] = 32'h0000_0013;
    mem[32'h8 >> 2]   = 32'h1234_5678;  ref_mem[32'h8 >> 2]   = 32'h1234_5678;

    //         iv pc       lv la      lw wd            ir lr  eir elr ewen eaddr    eiv eid            elv eld
    vec[0]  = '{1, 32'h0,   1, 32'h80, 0, 32'h0,        1, 1,  1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0};
    vec[1]  = '{1, 32'h0,   1, 32'h80, 0, 32'h0,        1, 1,  0, 1, 0, 32'h80,  1, 32'hA0000000, 0, 32'h0};
    vec[2]  = '{1, 32'h0,   1, 32'h80, 0, 32'h0,        1, 1,  1, 0, 0, 32'h0,   0, 32'h0,        1, 32'hA0000080};
    vec[3]  = '{1, 32'h0,   1, 32'h80, 0, 32'h0,        1, 1,  0, 1, 0, 32'h80,  1, 32'hA0000000, 0, 32'h0};
    vec[4]  = '{0, 32'h0,   0, 32'h0,  0, 32'h0,        1, 1,  0, 0, 0, 32'h0,   0, 32'h0,        1, 32'hA0000080};
    vec[5]  = '{0, 32'h0,   1, 32'h40, 1, 32'hDEADBEEF, 1, 1,  0, 1, 1, 32'h40,  0, 32'h0,        0, 32'h0};
    vec[6]  = '{0, 32'h0,   1, 32'h40, 0, 32'h0,        1, 1,  0, 1, 0, 32'h40,  0, 32'h0,        0, 32'h0};
    vec[7]  = '{0, 32'h0,   0, 32'h0,  0, 32'h0,        1, 1,  0, 0, 0, 32'h0,   0, 32'h0,        1, 32'hDEADBEEF};
    vec[8]  = '{0, 32'h0,   1, 32'h10, 0, 32'h0,        1, 1,  0, 1, 0, 32'h10,  0, 32'h0,        0, 32'h0};
    vec[9]  = '{0, 32'h0,   1, 32'h14, 0, 32'h0,        1, 1,  0, 1, 0, 32'h14,  0, 32'h0,        1, 32'hA0000010};
    vec[10] = '{0, 32'h0,   0, 32'h0,  0, 32'h0,        1, 1,  0, 0, 0, 32'h0,   0, 32'h0,        1, 32'hA0000014};
    vec[11] = '{1, 32'h100, 0, 32'h0,  0, 32'h0,        1, 1,  1, 0, 0, 32'h100, 0, 32'h0,        0, 32'h0};
    vec[12] = '{1, 32'h100, 0, 32'h0,  0, 32'h0,        1, 1,  1, 0, 0, 32'h100, 1, 32'h00000013, 0, 32'h0};
    vec[13] = '{0, 32'h100, 0, 32'h0,  0, 32'h0,        1, 1,  0, 0, 0, 32'h100, 1, 32'h00000013, 0, 32'h0};

    // Reset state with both requesters pushing
    drive(1, 32'h100, 1, 32'h40, 1, 32'h1111_1111, 1, 1);
    #3;
    chk("rst ifu_req_rdy", bus.ifu_req_rdy, 0);
    chk("rst lsu_req_rdy", bus.lsu_req_rdy, 0);
    chk("rst ifu_rsp_vld", bus.ifu_rsp_vld, 0);
    chk("rst lsu_rsp_vld", bus.lsu_rsp_vld, 0);
    chk("rst wen", bus.wen, 0);
    chk("rst addr", bus.addr, 0);
    chk("rst ifu_rsp_inst", bus.ifu_rsp_inst, 0);
    chk("rst lsu_rsp_rdata", bus.lsu_rsp_rdata, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      cycle(vec[i].iv, vec[i].pc, vec[i].lv, vec[i].la, vec[i].lw, vec[i].wd, vec[i].ir, vec[i].lr);
      chk($sformatf("vec%0d ifu_req_rdy", i), bus.ifu_req_rdy, vec[i].e_ir);
      chk($sformatf("vec%0d lsu_req_rdy", i), bus.lsu_req_rdy, vec[i].e_lr);
      chk($sformatf("vec%0d wen", i), bus.wen, vec[i].e_wen);
      chk($sformatf("vec%0d addr", i), bus.addr, vec[i].e_addr);
      chk($sformatf("vec%0d ifu_rsp_vld", i), bus.ifu_rsp_vld, vec[i].e_iv);
      chk($sformatf("vec%0d lsu_rsp_vld", i), bus.lsu_rsp_vld, vec[i].e_lv);
      if (vec[i].e_iv) chk($sformatf("vec%0d ifu_rsp_inst", i), bus.ifu_rsp_inst, vec[i].e_id);
      if (vec[i].e_lv) chk($sformatf("vec%0d lsu_rsp_rdata", i), bus.lsu_rsp_rdata, vec[i].e_ld);
      if (vec[i].e_wen) chk($sformatf("vec%0d wdata", i), bus.wdata, vec[i].wd);
    end
    ref_mem[32'h40 >> 2] = 32'hDEAD_BEEF;

    // IFU response backpressured for 3 cycles while LSU waits
    cycle(1, 32'h8, 0, 32'h0, 0, 0, 0, 1);
    chk("bp ifu grant", bus.ifu_req_rdy, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 32'h8, 1, 32'h80, 0, 0, 0, 1);
      chk($sformatf("bp%0d ifu_rsp_vld", k), bus.ifu_rsp_vld, 1);
      chk($sformatf("bp%0d ifu_rsp_inst", k), bus.ifu_rsp_inst, 32'h1234_5678);
      chk($sformatf("bp%0d lsu_req_rdy", k), bus.lsu_req_rdy, 0);
    end
    cycle(0, 32'h8, 1, 32'h80, 0, 0, 1, 1);
    chk("bp accept ifu_rsp_vld", bus.ifu_rsp_vld, 1);
    chk("bp accept ifu_rsp_inst", bus.ifu_rsp_inst, 32'h1234_5678);
    chk("bp accept lsu_req_rdy", bus.lsu_req_rdy, 0);
    cycle(0, 32'h8, 1, 32'h80, 0, 0, 1, 1);
    chk("bp after ifu_rsp_vld", bus.ifu_rsp_vld, 0);
    chk("bp after lsu_req_rdy", bus.lsu_req_rdy, 1);
    chk("bp after addr", bus.addr, 32'h80);
    cycle(0, 32'h8, 0, 32'h0, 0, 0, 1, 1);
    chk("bp lsu_rsp_vld", bus.lsu_rsp_vld, 1);
    chk("bp lsu_rsp_rdata", bus.lsu_rsp_rdata, 32'hA000_0080);

    // Reset while an IFU read is in flight and a store is pending
    cycle(1, 32'h8, 0, 32'h0, 0, 0, 1, 1);
    chk("rr ifu grant", bus.ifu_req_rdy, 1);
    @(posedge clk); #1;
    drive(1, 32'h8, 1, 32'h60, 1, 32'hBAD0_BAD0, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("rr ifu_rsp_vld", bus.ifu_rsp_vld, 0);
    chk("rr lsu_rsp_vld", bus.lsu_rsp_vld, 0);
    chk("rr ifu_req_rdy", bus.ifu_req_rdy, 0);
    chk("rr lsu_req_rdy", bus.lsu_req_rdy, 0);
    chk("rr wen", bus.wen, 0);
    chk("rr addr", bus.addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.lsu_req_wen = 1'b0;
    #1;
    chk("rr rel ifu_rsp_vld", bus.ifu_rsp_vld, 0);
    chk("rr rel lsu_rsp_vld", bus.lsu_rsp_vld, 0);
    chk("rr rel ifu_req_rdy", bus.ifu_req_rdy, 1);
    chk("rr rel lsu_req_rdy", bus.lsu_req_rdy, 0);
    cycle(1, 32'h8, 1, 32'h60, 0, 0, 1, 1);
    chk("rr 2nd lsu_req_rdy", bus.lsu_req_rdy, 1);
    chk("rr 2nd ifu_rsp_inst", bus.ifu_rsp_inst, 32'h1234_5678);
    cycle(0, 32'h8, 0, 32'h0, 0, 0, 1, 1);
    chk("rr lsu_rsp_vld", bus.lsu_rsp_vld, 1);
    chk("rr store dropped", bus.lsu_rsp_rdata, 32'hA000_0060);
    cycle(0, 32'h8, 0, 32'h0, 0, 0, 1, 1);

    // Randomized traffic against the reference model
    pend_vld = 0; pend_own = 0; pend_first = 0; pend_data = '0;
    fav_lsu = 0;
    iv = 0; lv = 0; lw = 0; pc = 0; la = 0; wd = 0; ihs = 0; lhs = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!iv || ihs) begin
        iv = ($urandom_range(0, 99) < 60);
        pc = $urandom_range(0, 1023) << 2;
      end
      if (!lv || lhs) begin
        lv = ($urandom_range(0, 99) < 60);
        la = $urandom_range(0, 1023) << 2;
        lw = ($urandom_range(0, 2) == 0);
        wd = $urandom;
      end
      ir = ($urandom_range(0, 99) < 70);
      lr = ($urandom_range(0, 99) < 70);
      drive(iv, pc, lv, la, lw, wd, ir, lr);
      @(negedge clk);

      own_rdy = pend_own ? lr : ir;
      can     = !pend_vld || (pend_first && own_rdy);
      e_ig    = can && iv && (!lv || !fav_lsu);
      e_lg    = can && lv && (!iv || fav_lsu);

      chk("rnd ifu_rsp_vld", bus.ifu_rsp_vld, pend_vld && !pend_own);
      chk("rnd lsu_rsp_vld", bus.lsu_rsp_vld, pend_vld && pend_own);
      if (pend_vld && !pend_own) chk("rnd ifu_rsp_inst", bus.ifu_rsp_inst, pend_data);
      if (pend_vld && pend_own)  chk("rnd lsu_rsp_rdata", bus.lsu_rsp_rdata, pend_data);
      chk("rnd ifu_req_rdy", bus.ifu_req_rdy, e_ig);
      chk("rnd lsu_req_rdy", bus.lsu_req_rdy, e_lg);
      chk("rnd wen", bus.wen, e_lg && lw);
      chk("rnd addr", bus.addr, e_lg ? la : pc);
      chk("rnd rsp exclusive", bus.ifu_rsp_vld & bus.lsu_rsp_vld, 0);

      ihs = bus.ifu_req_vld & bus.ifu_req_rdy;
      lhs = bus.lsu_req_vld & bus.lsu_req_rdy;

      if (pend_vld && own_rdy) pend_vld = 0;
      else if (pend_vld)       pend_first = 0;
      if (e_ig) begin
        pend_vld = 1; pend_own = 0; pend_first = 1;
        pend_data = ref_mem[pc[11:2]];
        fav_lsu = 1;
      end
      if (e_lg) begin
        fav_lsu = 0;
        if (lw) ref_mem[la[11:2]] = wd;
        else begin
          pend_vld = 1; pend_own = 1; pend_first = 1;
          pend_data = ref_mem[la[11:2]];
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
